load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory side of the core's load/store control path.
- Consumes memWrite, loadCtrl (funct3) and storeCtrl (funct3[1:0]) from the main decoder, plus the ALU-computed address and the rs2 store data.
- Drives a single-outstanding req/ack data bus: byte-lane enables and data replication on stores, lane extraction and sign/zero extension on loads.
- Signals completion or error back to the core and stalls the core while an access is in flight.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles to wait for busAck before aborting. Legal range 1..65535.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- memReq  input  1  core requests an access this cycle; sampled only in IDLE.
- memWrite  input  1  1=store, 0=load; captured with memReq.
- loadCtrl  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- storeCtrl  input  2  00 SB, 01 SH, 10 SW.
- addr  input  ADDR_W  byte address.
- storeData  input  32  rs2 value; low byte/half used for SB/SH.
- loadData  output  32  extended load result; valid when lsuDone=1 and lsuErr=0.
- lsuBusy  output  1  1 from the cycle after an accepted memReq through the DONE cycle inclusive.
- lsuDone  output  1  one-cycle completion pulse.
- lsuErr  output  1  qualifies lsuDone: illegal ctrl, misaligned access, or timeout.
- busReq  output  1  bus request, held until busAck or timeout.
- busWe  output  1  bus write enable.
- busAddr  output  ADDR_W  word-aligned address: addr with [1:0] forced to 00.
- busWData  output  32  replicated store data.
- busByteEn  output  4  active byte lanes.
- busRData  input  32  read data; valid with busAck.
- busAck  input  1  one-cycle bus acknowledge.

Behaviour:
- Reset: state=IDLE and every output is 0, including loadData. Applies mid-access too: busReq drops at that edge and no lsuDone is generated.
- States: IDLE, ACCESS, DONE.
- IDLE, on memReq=1:
  - Register addr, storeData, memWrite, loadCtrl and storeCtrl.
  - Compute byte enables and replicated data from the registered values.
  - Legal and aligned access: go to ACCESS.
  - Illegal or misaligned access: go to DONE with errFlag set. No bus cycle is issued.
- memReq outside IDLE is ignored. The core holds its request inputs stable while lsuBusy=1.
- Illegal ctrl values: loadCtrl 011/110/111 on loads; storeCtrl 11 on stores.
- ACCESS:
  - busReq=1. busWe, busAddr, busWData and busByteEn are registered and stable for the whole state.
  - Timeout counter starts at 0 on entry and increments each ACCESS cycle.
  - busAck=1: loads register the formatted busRData into loadData. Go to DONE with errFlag=0.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: go to DONE with errFlag=1; loadData is unchanged.
  - Ack in the same cycle as the timeout: ack wins.
- DONE: lsuDone=1 and lsuErr=errFlag for exactly one cycle, then IDLE. busReq=0.
- loadData holds its value until the next successful load.
- Latency: memReq at cycle 0, busReq from cycle 1, busAck at cycle k≥1, lsuDone at cycle k+1. Best case is 2 cycles. The error path gives lsuDone at cycle 1.
- Byte enables:
  - SB/LB/LBU: 0001<<addr[1:0].
  - SH/LH/LHU: 0011<<{addr[1],1'b0}.
  - SW/LW: 1111.
- busWData:
  - SB: {4{storeData[7:0]}}.
  - SH: {2{storeData[15:0]}}.
  - SW: storeData.
- Load formatting:
  - Select the byte at busRData[8*addr[1:0]+:8] or the half at busRData[16*addr[1]+:16].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the full word.
- Misaligned: addr[0]=1 for halfword accesses; addr[1:0]≠00 for word accesses. Byte accesses are never misaligned.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access takes the error path to DONE with lsuErr=1 and issues no bus cycle.
- Undefined: misalignment is not checked. The access proceeds with the low address bits truncated to the natural alignment:
  - Halfword: addr[0] treated as 0.
  - Word: addr[1:0] treated as 00.
- Undefined: only illegal ctrl values and timeout raise lsuErr.

Test Plan:
- SB, addr=0x1003, storeData=0xAABBCCDD, busAck in cycle 1 -> busAddr=0x1000, busByteEn=1000, busWData=0xDDDDDDDD, busWe=1; lsuDone=1 with lsuErr=0 in cycle 2.
- LB, addr=0x2002, busRData=0x0080FF00, ack after 3 wait cycles -> loadData=0xFFFFFF80, lsuDone 4 cycles after busReq rises. Repeat with LBU -> 0x00000080.
- LHU, addr=0x2002, busRData=0x8001_1234 -> busByteEn=1100, loadData=0x00008001. LH on the same data -> 0xFFFF8001.
- LW, addr=0x3002, macro defined -> no busReq, lsuDone=1 and lsuErr=1 in cycle 1. Macro undefined -> busAddr=0x3000, busByteEn=1111, lsuErr=0.
- TIMEOUT_CYCLES=4, no busAck -> busReq high exactly 4 cycles, then lsuDone=1 with lsuErr=1 and loadData unchanged. busAck on the 4th cycle instead -> lsuErr=0.
- rst=1 during ACCESS, then busAck pulsed after rst deasserts -> busReq=0 at the reset edge; no lsuDone; the ack is ignored in IDLE. loadCtrl=011 -> error path with lsuErr=1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding req/ack data-bus master with lane steering and load extension.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise low address bits are truncated.
module load_store_unit #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memReq,
   input  logic              memWrite,
   input  logic [2:0]        loadCtrl,
   input  logic [1:0]        storeCtrl,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       storeData,
   output logic [31:0]       loadData,
   output logic              lsuBusy,
   output logic              lsuDone,
   output logic              lsuErr,
   output logic              busReq,
   output logic              busWe,
   output logic [ADDR_W-1:0] busAddr,
   output logic [31:0]       busWData,
   output logic [3:0]        busByteEn,
   input  logic [31:0]       busRData,
   input  logic              busAck
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // Size encoding shared by loadCtrl[1:0] and storeCtrl: 00 byte, 01 half, 10 word.
   localparam logic [1:0]  C_SZ_BYTE  = 2'b00;
   localparam logic [1:0]  C_SZ_HALF  = 2'b01;
   localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   logic [1:0]        r_addr_lo;
   logic [2:0]        r_load_ctrl;
   logic [15:0]       r_tmo;
   logic [31:0]       r_load_data;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              r_bus_req;
   logic              r_bus_we;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [31:0]       r_bus_wdata;
   logic [3:0]        r_bus_be;

   logic [1:0]        w_size;
   logic              w_illegal;
   logic              w_req_err;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [ADDR_W-1:0] w_bus_addr;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load_fmt;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_size    = memWrite ? storeCtrl : loadCtrl[1:0];
      w_illegal = 1'b0;
      if (memWrite) begin
         w_illegal = (storeCtrl == 2'b11);
      end else begin
         case (loadCtrl)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
            default:                                w_illegal = 1'b1;
         endcase
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic w_misalign;

   always_comb begin
      w_misalign = 1'b0;
      if (w_size == C_SZ_HALF) begin
         w_misalign = addr[0];
      end else if (w_size != C_SZ_BYTE) begin
         w_misalign = (addr[1:0] != 2'b00);
      end
   end

   assign w_req_err = w_illegal | w_misalign;
`else
   assign w_req_err = w_illegal;
`endif

   // Halfword lanes ignore addr[0] and word lanes ignore addr[1:0], which gives the truncation for free.
   always_comb begin
      w_bus_addr = {addr[ADDR_W-1:2], 2'b00};
      case (w_size)
         C_SZ_BYTE: begin
            w_be    = 4'b0001 << addr[1:0];
            w_wdata = {4{storeData[7:0]}};
         end
         C_SZ_HALF: begin
            w_be    = addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{storeData[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = storeData;
         end
      endcase
   end

   always_comb begin
      case (r_addr_lo)
         2'd0:    w_byte = busRData[7:0];
         2'd1:    w_byte = busRData[15:8];
         2'd2:    w_byte = busRData[23:16];
         default: w_byte = busRData[31:24];
      endcase
      w_half = r_addr_lo[1] ? busRData[31:16] : busRData[15:0];
      case (r_load_ctrl)
         3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_fmt = {24'd0, w_byte};
         3'b101:  w_load_fmt = {16'd0, w_half};
         default: w_load_fmt = busRData;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr_lo   <= 2'b00;
         r_load_ctrl <= 3'b000;
         r_tmo       <= 16'd0;
         r_load_data <= 32'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= 32'd0;
         r_bus_be    <= 4'b0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (memReq) begin
                  r_addr_lo   <= addr[1:0];
                  r_load_ctrl <= loadCtrl;
                  r_busy      <= 1'b1;
                  if (w_req_err) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state     <= S_ACCESS;
                     r_tmo       <= 16'd0;
                     r_bus_req   <= 1'b1;
                     r_bus_we    <= memWrite;
                     r_bus_addr  <= w_bus_addr;
                     r_bus_wdata <= w_wdata;
                     r_bus_be    <= w_be;
                  end
               end
            end
            S_ACCESS: begin
               // Ack is tested first so an ack on the final timeout cycle still completes cleanly.
               if (busAck || (r_tmo == C_TMO_LAST)) begin
                  if (busAck && !r_bus_we) begin
                     r_load_data <= w_load_fmt;
                  end
                  r_state     <= S_DONE;
                  r_done      <= 1'b1;
                  r_err       <= ~busAck;
                  r_bus_req   <= 1'b0;
                  r_bus_we    <= 1'b0;
                  r_bus_addr  <= '0;
                  r_bus_wdata <= 32'd0;
                  r_bus_be    <= 4'b0000;
               end else begin
                  r_tmo <= r_tmo + 16'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign loadData  = r_load_data;
   assign lsuBusy   = r_busy;
   assign lsuDone   = r_done;
   assign lsuErr    = r_err;
   assign busReq    = r_bus_req;
   assign busWe     = r_bus_we;
   assign busAddr   = r_bus_addr;
   assign busWData  = r_bus_wdata;
   assign busByteEn = r_bus_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset-during-access sequence,
// and randomized transactions against a byte-level reference model.
module tb_load_store_unit;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        memReq;
   logic        memWrite;
   logic [2:0]  loadCtrl;
   logic [1:0]  storeCtrl;
   logic [31:0] addr;
   logic [31:0] storeData;
   logic [31:0] loadData;
   logic        lsuBusy;
   logic        lsuDone;
   logic        lsuErr;
   logic        busReq;
   logic        busWe;
   logic [31:0] busAddr;
   logic [31:0] busWData;
   logic [3:0]  busByteEn;
   logic [31:0] busRData;
   logic        busAck;

   load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .memReq(memReq), .memWrite(memWrite),
      .loadCtrl(loadCtrl), .storeCtrl(storeCtrl), .addr(addr), .storeData(storeData),
      .loadData(loadData), .lsuBusy(lsuBusy), .lsuDone(lsuDone), .lsuErr(lsuErr),
      .busReq(busReq), .busWe(busWe), .busAddr(busAddr), .busWData(busWData),
      .busByteEn(busByteEn), .busRData(busRData), .busAck(busAck)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [2:0]  lc;
      logic [1:0]  sc;
      logic [31:0] a;
      logic [31:0] sd;
      logic [31:0] rd;
      int          d;      // ACCESS cycles without ack before the ack; >= T means never
   } stim_t;

   typedef struct {
      int          done;   // cycle of lsuDone, memReq in cycle 0
      logic        err;
      int          req;    // number of busReq cycles
      logic [31:0] baddr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] load;   // loadData after the access
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   int          o_done, o_req, o_busy;
   logic        o_err, o_we, o_stable, o_post_busy, o_post_done;
   logic [31:0] o_load, o_addr, o_wdata;
   logic [3:0]  o_be;
   logic [31:0] m_load;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   function automatic stim_t mks(input logic wr, input logic [2:0] lc, input logic [1:0] sc,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rd, input int d);
      stim_t s;
      s.wr = wr; s.lc = lc; s.sc = sc; s.a = a; s.sd = sd; s.rd = rd; s.d = d;
      return s;
   endfunction

   function automatic exp_t mke(input int done, input logic err, input int req,
                                input logic [31:0] baddr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] load);
      exp_t e;
      e.done = done; e.err = err; e.req = req; e.baddr = baddr;
      e.be = be; e.wdata = wdata; e.load = load;
      return e;
   endfunction

   // Reference model: access size in bytes, alignment by modulo, lanes by byte-wise replication.
   function automatic exp_t model(input stim_t s, input logic [31:0] prev);
      exp_t    e;
      int      size, lane;
      bit      legal, misal, sgn;
      longint  eff, mask, v;
      if (s.wr) begin
         legal = (s.sc != 2'd3);
         size  = (s.sc == 2'd0) ? 1 : (s.sc == 2'd1) ? 2 : 4;
         sgn   = 1'b0;
      end else begin
         legal = (s.lc == 3'd0) || (s.lc == 3'd1) || (s.lc == 3'd2) || (s.lc == 3'd4) || (s.lc == 3'd5);
         size  = (s.lc[1:0] == 2'd0) ? 1 : (s.lc[1:0] == 2'd1) ? 2 : 4;
         sgn   = (s.lc[2] == 1'b0);
      end
`ifdef LSU_MISALIGN_TRAP_EN
      misal = (longint'(s.a) % size) != 0;
`else
      misal = 1'b0;
`endif
      e = mke(1, 1'b1, 0, 32'd0, 4'd0, 32'd0, prev);
      if (legal && !misal) begin
         eff     = longint'(s.a) - (longint'(s.a) % size);
         lane    = int'(eff % 4);
         e.baddr = 32'(eff - lane);
         e.be    = 4'(((1 << size) - 1) << lane);
         for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = s.sd[8*(i % size) +: 8];
         if (s.d >= T) begin
            e.req = T; e.done = T + 1; e.err = 1'b1;
         end else begin
            e.req = s.d + 1; e.done = s.d + 2; e.err = 1'b0;
            if (!s.wr) begin
               mask = (64'd1 << (8 * size)) - 1;
               v    = (longint'(s.rd) >> (8 * lane)) & mask;
               if (sgn && size < 4 && ((v >> (8 * size - 1)) & 1) == 1) v = v | ~mask;
               e.load = 32'(v);
            end
         end
      end
      return e;
   endfunction

   // Starts in an IDLE cycle, #1 after a rising edge; ends #1 after the edge following lsuDone.
   task automatic run(input stim_t s);
      memReq = 1'b1; memWrite = s.wr; loadCtrl = s.lc; storeCtrl = s.sc;
      addr = s.a; storeData = s.sd; busRData = s.rd; busAck = 1'b0;
      o_done = -1; o_err = 1'b0; o_req = 0; o_busy = 0; o_stable = 1'b1; o_load = 32'd0;
      o_addr = 32'd0; o_be = 4'd0; o_wdata = 32'd0; o_we = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         memReq = 1'b0;
         busAck = 1'b0;
         if (busReq) begin
            o_req++;
            if (o_req == 1) begin
               o_addr = busAddr; o_be = busByteEn; o_wdata = busWData; o_we = busWe;
            end else if (busAddr !== o_addr || busByteEn !== o_be || busWData !== o_wdata || busWe !== o_we) begin
               o_stable = 1'b0;
            end
            if (o_req == s.d + 1) busAck = 1'b1;
         end
         if (lsuBusy) o_busy++;
         if (lsuDone) begin
            o_done = c; o_err = lsuErr; o_load = loadData;
            break;
         end
      end
      @(posedge clk); #1;
      busAck = 1'b0;
      o_post_busy = lsuBusy;
      o_post_done = lsuDone;
   endtask

   task automatic verify(input string tag, input stim_t s, input exp_t e);
      check({tag, " done_cycle"}, o_done, e.done);
      check({tag, " lsuErr"}, {31'd0, o_err}, {31'd0, e.err});
      check({tag, " busReq_cycles"}, o_req, e.req);
      check({tag, " busy_cycles"}, o_busy, e.done);
      check({tag, " busy_after"}, {31'd0, o_post_busy}, 32'd0);
      check({tag, " done_pulse"}, {31'd0, o_post_done}, 32'd0);
      check({tag, " loadData"}, o_load, e.load);
      if (e.req > 0) begin
         check({tag, " busAddr"}, o_addr, e.baddr);
         check({tag, " busByteEn"}, {28'd0, o_be}, {28'd0, e.be});
         check({tag, " busWe"}, {31'd0, o_we}, {31'd0, s.wr});
         check({tag, " bus_stable"}, {31'd0, o_stable}, 32'd1);
         if (s.wr) check({tag, " busWData"}, o_wdata, e.wdata);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  tbl[14];
      stim_t s;
      exp_t  e;
      int    n_done_seen, n_req_seen;

      tbl[0]  = '{mks(1, 3'd0, 2'd0, 32'h1003, 32'hAABBCCDD, 32'h0, 0),
                  mke(2, 0, 1, 32'h1000, 4'b1000, 32'hDDDDDDDD, 32'h0)};
      tbl[1]  = '{mks(0, 3'd0, 2'd0, 32'h2002, 32'h0, 32'h0080FF00, 3),
                  mke(5, 0, 4, 32'h2000, 4'b0100, 32'h0, 32'hFFFFFF80)};
      tbl[2]  = '{mks(0, 3'd4, 2'd0, 32'h2002, 32'h0, 32'h0080FF00, 3),
                  mke(5, 0, 4, 32'h2000, 4'b0100, 32'h0, 32'h00000080)};
      tbl[3]  = '{mks(0, 3'd5, 2'd0, 32'h2002, 32'h0, 32'h80011234, 0),
                  mke(2, 0, 1, 32'h2000, 4'b1100, 32'h0, 32'h00008001)};
      tbl[4]  = '{mks(0, 3'd1, 2'd0, 32'h2002, 32'h0, 32'h80011234, 0),
                  mke(2, 0, 1, 32'h2000, 4'b1100, 32'h0, 32'hFFFF8001)};
      tbl[5]  = '{mks(0, 3'd2, 2'd0, 32'h4000, 32'h0, 32'hDEADBEEF, 99),
                  mke(5, 1, 4, 32'h4000, 4'b1111, 32'h0, 32'hFFFF8001)};
      tbl[6]  = '{mks(0, 3'd2, 2'd0, 32'h4000, 32'h0, 32'h0BADF00D, 3),
                  mke(5, 0, 4, 32'h4000, 4'b1111, 32'h0, 32'h0BADF00D)};
`ifdef LSU_MISALIGN_TRAP_EN
      tbl[7]  = '{mks(0, 3'd2, 2'd0, 32'h3002, 32'h0, 32'h12345678, 0),
                  mke(1, 1, 0, 32'h0, 4'b0000, 32'h0, 32'h0BADF00D)};
`else
      tbl[7]  = '{mks(0, 3'd2, 2'd0, 32'h3002, 32'h0, 32'h12345678, 0),
                  mke(2, 0, 1, 32'h3000, 4'b1111, 32'h0, 32'h12345678)};
`endif
      tbl[8]  = '{mks(0, 3'd4, 2'd0, 32'h0001, 32'h0, 32'h0000A500, 0),
                  mke(2, 0, 1, 32'h0000, 4'b0010, 32'h0, 32'h000000A5)};
      tbl[9]  = '{mks(0, 3'd3, 2'd0, 32'h5000, 32'h0, 32'hFFFFFFFF, 0),
                  mke(1, 1, 0, 32'h0, 4'b0000, 32'h0, 32'h000000A5)};
      tbl[10] = '{mks(0, 3'd6, 2'd0, 32'h5000, 32'h0, 32'hFFFFFFFF, 0),
                  mke(1, 1, 0, 32'h0, 4'b0000, 32'h0, 32'h000000A5)};
      tbl[11] = '{mks(1, 3'd0, 2'd3, 32'h5000, 32'h11223344, 32'h0, 0),
                  mke(1, 1, 0, 32'h0, 4'b0000, 32'h0, 32'h000000A5)};
      tbl[12] = '{mks(1, 3'd0, 2'd1, 32'h0006, 32'h1234ABCD, 32'h0, 1),
                  mke(3, 0, 2, 32'h0004, 4'b1100, 32'hABCDABCD, 32'h000000A5)};
      tbl[13] = '{mks(1, 3'd0, 2'd2, 32'h0008, 32'hCAFEF00D, 32'h0, 2),
                  mke(4, 0, 3, 32'h0008, 4'b1111, 32'hCAFEF00D, 32'h000000A5)};

      rst = 1'b1; memReq = 1'b0; memWrite = 1'b0; loadCtrl = 3'd0; storeCtrl = 2'd0;
      addr = 32'd0; storeData = 32'd0; busRData = 32'd0; busAck = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busReq",    {31'd0, busReq},    32'd0);
      check("reset busWe",     {31'd0, busWe},     32'd0);
      check("reset busAddr",   busAddr,            32'd0);
      check("reset busWData",  busWData,           32'd0);
      check("reset busByteEn", {28'd0, busByteEn}, 32'd0);
      check("reset loadData",  loadData,           32'd0);
      check("reset lsuBusy",   {31'd0, lsuBusy},   32'd0);
      check("reset lsuDone",   {31'd0, lsuDone},   32'd0);
      check("reset lsuErr",    {31'd0, lsuErr},    32'd0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         run(tbl[i].s);
         verify($sformatf("vec%0d", i), tbl[i].s, tbl[i].e);
      end

      // Reset in the middle of ACCESS, then a stray ack while IDLE.
      memReq = 1'b1; memWrite = 1'b0; loadCtrl = 3'd2; storeCtrl = 2'd0; addr = 32'h100;
      @(posedge clk); #1;
      memReq = 1'b0;
      check("midrst busReq_c1", {31'd0, busReq}, 32'd1);
      @(posedge clk); #1;
      check("midrst busReq_c2", {31'd0, busReq}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst busReq_at_reset", {31'd0, busReq},  32'd0);
      check("midrst lsuBusy_at_reset", {31'd0, lsuBusy}, 32'd0);
      check("midrst loadData_at_reset", loadData,        32'd0);
      rst = 1'b0;
      busAck = 1'b1;
      n_done_seen = 0; n_req_seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         busAck = 1'b0;
         if (lsuDone) n_done_seen++;
         if (busReq) n_req_seen++;
      end
      check("midrst no_lsuDone", n_done_seen, 0);
      check("midrst no_busReq", n_req_seen, 0);
      m_load = 32'd0;

      for (int i = 0; i < 300; i++) begin
         s.wr = 1'($urandom_range(0, 1));
         s.lc = 3'($urandom_range(0, 7));
         s.sc = 2'($urandom_range(0, 3));
         s.a  = $urandom;
         if ($urandom_range(0, 1) == 1) s.a[1:0] = 2'b00;
         s.sd = $urandom;
         s.rd = $urandom;
         s.d  = $urandom_range(0, T + 1);
         e = model(s, m_load);
         run(s);
         verify($sformatf("rnd%0d", i), s, e);
         m_load = e.load;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
